// File: rtl/rwt_pkg.sv
// Shared widths, state encoding and the lane-compaction helper for the sample packer.
package rwt_pkg;
    localparam int SWIDTH = 16;
    localparam int DWIDTH = 64;
    localparam int NLANES = DWIDTH / SWIDTH;
    localparam int KW     = $clog2(NLANES + 1);
    localparam int CW     = $clog2(NLANES);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [KW-1:0]     k;
    } compact_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    // Enabled lanes move down to the lowest free slot; everything above k stays zero.
    function automatic compact_t compact_lanes(input logic [DWIDTH-1:0] data,
                                               input logic [NLANES-1:0] en);
        compact_t    res;
        int unsigned idx;
        res = '0;
        idx = 0;
        for (int i = 0; i < NLANES; i++) begin
            if (en[i]) begin
                res.data[idx*SWIDTH +: SWIDTH] = data[i*SWIDTH +: SWIDTH];
                idx++;
            end
        end
        res.k = KW'(idx);
        return res;
    endfunction
endpackage

// File: rtl/rwt_lane_compact.sv
// Combinational compaction of one input beat: enabled lanes packed low, plus their count.
module rwt_lane_compact
    import rwt_pkg::*;
(
    input  logic [DWIDTH-1:0] data,
    input  logic [NLANES-1:0] enables,
    output logic [DWIDTH-1:0] packed_data,
    output logic [KW-1:0]     k
);
    compact_t res;

    always_comb begin
        res         = compact_lanes(data, enables);
        packed_data = res.data;
        k           = res.k;
    end
endmodule

// File: rtl/rwt_sample_packer.sv
// Packs enabled 16-bit lanes of an AXI-Stream into dense words; widths must match rwt_pkg.
//
// state    | meaning
// ST_INIT  | first cycle after reset, input held off
// ST_RUN   | normal packing, one beat per cycle when the output slot is free
// ST_FLUSH | last beat overflowed one word; remainder emitted next, input held off
module rwt_sample_packer #(
    parameter int DWIDTH = rwt_pkg::DWIDTH,
    parameter int SWIDTH = rwt_pkg::SWIDTH
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [DWIDTH-1:0]          s_axi_data,
    input  logic [DWIDTH/SWIDTH-1:0]   s_axi_enables,
    input  logic                       s_axi_valid,
    input  logic                       s_axi_last,
    output logic                       s_axi_ready,
    output logic [DWIDTH-1:0]          m_axi_data,
    output logic                       m_axi_valid,
    output logic                       m_axi_last,
    input  logic                       m_axi_ready
);
    localparam int NLANES = DWIDTH / SWIDTH;
    localparam int KW     = rwt_pkg::KW;
    localparam int CW     = rwt_pkg::CW;

    rwt_pkg::state_t   state_q, state_d;
    logic [DWIDTH-1:0] pend_data, pend_data_d;
    logic [CW-1:0]     pend_count, pend_count_d;
    logic [DWIDTH-1:0] new_data;
    logic [KW-1:0]     new_k;
    logic [KW-1:0]     total;
    logic [2*DWIDTH-1:0] cat;
    logic [DWIDTH-1:0] odata_d;
    logic              ovalid_d, olast_d;
    logic              slot_free, accept, overflow_last;

    rwt_lane_compact u_compact (
        .data        (s_axi_data),
        .enables     (s_axi_enables),
        .packed_data (new_data),
        .k           (new_k)
    );

    assign slot_free     = !m_axi_valid || m_axi_ready;
    assign accept        = s_axi_valid && s_axi_ready;
    assign total         = KW'(pend_count) + new_k;
    assign overflow_last = total > KW'(NLANES);

    // Pending samples occupy the low lanes (upper lanes kept zero), new samples land above them.
    assign cat = {{DWIDTH{1'b0}}, pend_data}
               | ({{DWIDTH{1'b0}}, new_data} << (SWIDTH * int'(pend_count)));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_q <= rwt_pkg::ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            rwt_pkg::ST_INIT:  state_d = rwt_pkg::ST_RUN;
            rwt_pkg::ST_RUN:   if (accept && s_axi_last && overflow_last) state_d = rwt_pkg::ST_FLUSH;
            rwt_pkg::ST_FLUSH: if (slot_free) state_d = rwt_pkg::ST_RUN;
            default:           state_d = rwt_pkg::ST_INIT;
        endcase
    end

    always_comb begin
        s_axi_ready = (state_q == rwt_pkg::ST_RUN) && slot_free;
    end

    always_comb begin
        pend_data_d  = pend_data;
        pend_count_d = pend_count;
        odata_d      = m_axi_data;
        olast_d      = m_axi_last;
        ovalid_d     = m_axi_valid && !m_axi_ready;
        if (state_q == rwt_pkg::ST_FLUSH) begin
            if (slot_free) begin
                odata_d      = pend_data;
                ovalid_d     = 1'b1;
                olast_d      = 1'b1;
                pend_data_d  = '0;
                pend_count_d = '0;
            end
        end else if (accept) begin
            if (s_axi_last) begin
                ovalid_d = 1'b1;
                odata_d  = cat[DWIDTH-1:0];
                if (overflow_last) begin
                    olast_d      = 1'b0;
                    pend_data_d  = cat[2*DWIDTH-1:DWIDTH];
                    pend_count_d = CW'(total - KW'(NLANES));
                end else begin
                    olast_d      = 1'b1;
                    pend_data_d  = '0;
                    pend_count_d = '0;
                end
            end else if (total >= KW'(NLANES)) begin
                ovalid_d     = 1'b1;
                olast_d      = 1'b0;
                odata_d      = cat[DWIDTH-1:0];
                pend_data_d  = cat[2*DWIDTH-1:DWIDTH];
                pend_count_d = CW'(total - KW'(NLANES));
            end else begin
                pend_data_d  = cat[DWIDTH-1:0];
                pend_count_d = CW'(total);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pend_data   <= '0;
            pend_count  <= '0;
            m_axi_data  <= '0;
            m_axi_valid <= 1'b0;
            m_axi_last  <= 1'b0;
        end else begin
            pend_data   <= pend_data_d;
            pend_count  <= pend_count_d;
            m_axi_data  <= odata_d;
            m_axi_valid <= ovalid_d;
            m_axi_last  <= olast_d;
        end
    end
endmodule

// File: tb/tb_rwt_sample_packer.sv
// Scoreboard bench for rwt_sample_packer: a sample-queue reference model predicts every word.
module tb_rwt_sample_packer;
    logic        clk = 1'b0;
    logic        areset;
    logic [63:0] s_axi_data;
    logic [3:0]  s_axi_enables;
    logic        s_axi_valid;
    logic        s_axi_last;
    logic        s_axi_ready;
    logic [63:0] m_axi_data;
    logic        m_axi_valid;
    logic        m_axi_last;
    logic        m_axi_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rand_ready = 1'b0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          acc;
        logic        lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];

    rwt_sample_packer dut (
        .clk           (clk),
        .areset        (areset),
        .s_axi_data    (s_axi_data),
        .s_axi_enables (s_axi_enables),
        .s_axi_valid   (s_axi_valid),
        .s_axi_last    (s_axi_last),
        .s_axi_ready   (s_axi_ready),
        .m_axi_data    (m_axi_data),
        .m_axi_valid   (m_axi_valid),
        .m_axi_last    (m_axi_last),
        .m_axi_ready   (m_axi_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) m_axi_ready = rand_ready ? ($urandom_range(0, 4) != 0) : 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic void push_word(input logic last, input int acc, input logic lat);
        exp_t e;
        e.data = '0;
        for (int j = 0; j < 4; j++)
            if (mq.size() > 0) e.data[j*16 +: 16] = mq.pop_front();
        e.last = last;
        e.acc  = acc;
        e.lat  = lat;
        exp_q.push_back(e);
    endfunction

    // Reference: samples queue up in arrival order; full words leave eagerly, last drains all.
    function automatic void model_beat(input logic [63:0] d, input logic [3:0] en,
                                       input logic l, input int acc, input logic lat);
        logic first;
        for (int i = 0; i < 4; i++)
            if (en[i]) mq.push_back(d[i*16 +: 16]);
        if (!l) begin
            while (mq.size() >= 4) push_word(1'b0, acc, lat);
        end else if (mq.size() == 0) begin
            push_word(1'b1, acc, lat);
        end else begin
            first = 1'b1;
            while (mq.size() > 0) begin
                push_word(mq.size() <= 4, acc, lat && first);
                first = 1'b0;
            end
        end
    endfunction

    // Call at a falling edge; returns at the falling edge after the beat was taken.
    task automatic send_beat(input logic [63:0] d, input logic [3:0] en,
                             input logic l, input logic lat);
        int t;
        s_axi_data    = d;
        s_axi_enables = en;
        s_axi_last    = l;
        s_axi_valid   = 1'b1;
        #1;
        t = 0;
        while (!s_axi_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!s_axi_ready) begin
            chk("accept_timeout", 64'(s_axi_ready), 64'(1));
            s_axi_valid = 1'b0;
        end else begin
            model_beat(d, en, l, cyc, lat);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        s_axi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        s_axi_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
    endtask

    logic        stalled = 1'b0;
    logic [63:0] held_data;
    logic        held_last;

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (areset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(m_axi_valid), 64'(1));
                chk("hold_data", m_axi_data, held_data);
                chk("hold_last", 64'(m_axi_last), 64'(held_last));
            end
            if (m_axi_valid && m_axi_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_axi_data, 64'(0));
                    chk("unexpected_valid", 64'(m_axi_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", m_axi_data, e.data);
                    chk("word_last", 64'(m_axi_last), 64'(e.last));
                    if (e.lat) chk("latency", 64'(cyc), 64'(e.acc + 1));
                end
            end
            stalled   = m_axi_valid && !m_axi_ready;
            held_data = m_axi_data;
            held_last = m_axi_last;
        end
    end

    initial begin
        areset        = 1'b1;
        s_axi_data    = '0;
        s_axi_enables = '0;
        s_axi_valid   = 1'b0;
        s_axi_last    = 1'b0;
        m_axi_ready   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(m_axi_valid), 64'(0));
        chk("rst_last", 64'(m_axi_last), 64'(0));
        chk("rst_data", m_axi_data, 64'(0));
        chk("rst_ready", 64'(s_axi_ready), 64'(0));
        chk("rst_count", 64'(dut.pend_count), 64'(0));
        areset = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_rst", 64'(s_axi_ready), 64'(1));
        @(negedge clk);

        // full lanes pass straight through at one word per cycle
        for (int i = 0; i < 6; i++)
            send_beat({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 4'b1111, 1'b0, 1'b1);
        drain();

        send_beat(mk(0, 1, 2, 3), 4'b0101, 1'b0, 1'b1);
        send_beat(mk(4, 5, 6, 7), 4'b0101, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 8; i++)
            send_beat(mk(16'(i), 16'($urandom), 16'($urandom), 16'($urandom)), 4'b0001, 1'b0, 1'b1);
        drain();

        // last beat overflows: expect a flush cycle with ready low
        send_beat(mk(0, 1, 2, 3), 4'b0111, 1'b0, 1'b1);
        send_beat(mk(4, 5, 6, 7), 4'b0111, 1'b0, 1'b1);
        send_beat(mk(8, 9, 10, 11), 4'b0111, 1'b1, 1'b1);
        s_axi_valid = 1'b0;
        #1;
        chk("flush_ready_low", 64'(s_axi_ready), 64'(0));
        @(negedge clk);
        #1;
        chk("flush_ready_back", 64'(s_axi_ready), 64'(1));
        @(negedge clk);
        drain();

        send_beat(mk(1, 2, 3, 4), 4'b0000, 1'b0, 1'b1);
        send_beat(mk(5, 6, 7, 8), 4'b0000, 1'b1, 1'b1);
        send_beat(mk(9, 10, 11, 12), 4'b1010, 1'b1, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send_beat({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
                      4'($urandom), ($urandom_range(0, 9) == 0) || (i == 79), 1'b0);
            if ($urandom_range(0, 5) == 0) idle();
        end
        drain();
        rand_ready = 1'b0;
        @(negedge clk);

        // reset with two samples pending; none may leak into the next packet
        send_beat(mk(16'hdead, 16'hbeef, 16'h1111, 16'h2222), 4'b0011, 1'b0, 1'b1);
        s_axi_valid = 1'b0;
        #1;
        chk("pre_reset_count", 64'(dut.pend_count), 64'(2));
        areset = 1'b1;
        #1;
        chk("midrst_valid", 64'(m_axi_valid), 64'(0));
        chk("midrst_last", 64'(m_axi_last), 64'(0));
        chk("midrst_count", 64'(dut.pend_count), 64'(0));
        chk("midrst_ready", 64'(s_axi_ready), 64'(0));
        mq.delete();
        @(negedge clk);
        areset = 1'b0;
        repeat (2) @(negedge clk);
        send_beat(mk(16'h00a1, 16'h00a2, 16'h00a3, 16'h00a4), 4'b1111, 1'b1, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
